// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/counter_sched_if.sv
// Requester-side bundle of the counter scheduler: requests in, grants/status out.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_len are held by the requester until req_ready pulses.
interface counter_sched_if
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*CNT_W-1:0] req_len;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [IDX_W-1:0]       owner;
    logic [CNT_W-1:0]       count;

    modport master (
        output req_valid, req_len,
        input  req_ready, done, busy, owner, count
    );

    modport slave (
        input  req_valid, req_len,
        output req_ready, done, busy, owner, count
    );

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(N_REQ);

    // Scan N_REQ slots starting at ptr; the first hit wins and later hits are masked.
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Time-shares one up-counter among N_REQ requesters, one interval of req_len cycles per grant.
// Latency: accept at T, count 0..L-1 during T+1..T+L, done pulse at T+L+1 (T+1 when L == 0).
// Backpressure: req_ready is offered only in IDLE; requests wait (held valid) while a job runs.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    counter_sched_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [CNT_W-1:0] sel_len;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Length of the winning requester, muxed by the one-hot grant.
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_len = bus.req_len[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state logic: grant in IDLE, count through RUN, report in DONE.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (arb_any) begin
                    len_d   = sel_len;
                    owner_d = arb_idx;
                    state_d = (sel_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (count_q == len_q - 1'b1) begin
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered off the next state so they line up with it.
        for (int i = 0; i < N_REQ; i++) begin
            done_d[i] = (state_d == DONE) && (owner_d == IDX_W'(i));
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset; a reset aborts any job silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? arb_gnt : '0;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.count     = count_q;

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that time-shares one up-counter among `N_REQ` requesters. Each requester asks for an interval of `L` clock cycles. The block grants one request at a time, runs the counter for exactly `L` cycles, then pulses a per-requester `done`. It sits in front of the day-5 style 8-bit counter datapath and is the only agent that starts, clears or reads it.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; valid range 2..8.
- `CNT_W`, default 8: counter and length width.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  `N_REQ`: requester i wants an interval.
- `req_len`  in  `N_REQ*CNT_W`: interval length for requester i, in slice `[i*CNT_W +: CNT_W]`.
- `req_ready`  out  `N_REQ`: one-hot accept strobe, one cycle.
- `done`  out  `N_REQ`: one-hot completion pulse, one cycle.
- `busy`  out  1: a job is in flight (RUN or DONE state).
- `owner`  out  `$clog2(N_REQ)`: index of the current or last granted requester.
- `count`  out  `CNT_W`: shared counter value.

## Operation
States are IDLE, RUN and DONE.
- **IDLE**
  - If any `req_valid` is high, choose the winner g by round-robin, starting the search at pointer `ptr`.
  - Assert `req_ready[g]` combinationally in this cycle; this is the only state in which `req_ready` can be high.
  - On the clock edge: latch `len_q <= req_len[g]`, `owner <= g`, `count <= 0`.
  - Go to RUN if `len_q != 0`; go directly to DONE if `len_q == 0`.
- **RUN**
  - `count` increments by 1 each cycle, showing 0, 1, …, L-1.
  - When `count == len_q - 1`: next state is DONE and `count` clears to 0.
  - `req_valid` and `req_len` are ignored during RUN.
- **DONE**
  - `done[owner]` is high for this one cycle.
  - `ptr <= owner + 1`, modulo `N_REQ`.
  - Next state is IDLE.
- **Handshake:** a request is accepted when `req_valid[i] && req_ready[i]`. A requester holds `req_valid` and `req_len` stable until accepted. It may keep `req_valid` high after `done` to queue another job; that job competes fairly in the next IDLE.
- **Arithmetic:** `len_q` is unsigned `CNT_W` bits, so the maximum interval is 2^CNT_W - 1 (255 by default). `count` never wraps because it stops at `len_q - 1`.
- **Outputs in IDLE:** `count = 0`, `busy = 0`. `owner` holds its last value.

## Timing
- **Reset values:** state IDLE, `ptr = 0`, `owner = 0`, `count = 0`, `len_q = 0`, `req_ready = 0`, `done = 0`, `busy = 0`.
- **Job latency:** accept at cycle T (IDLE), RUN during cycles T+1 … T+L, `done` at cycle T+L+1, next accept possible at T+L+2. For L = 0, `done` is at T+1.
- **Throughput:** one job per L+2 cycles.
- **Simultaneous requests:** exactly one grant per IDLE cycle. The lowest index at or after `ptr` wins, wrapping past `N_REQ-1` to 0.
- **Reset mid-operation (RUN or DONE):** the next cycle is IDLE with all reset values. No `done` is issued for the aborted job, and the requester must re-request.
- **`req_valid` drops in IDLE before accept:** no grant, no state change.
- **`busy`** is high in RUN and DONE.

## Structure
- Shared package `counter_sched_pkg`:
  - state enum `sched_state_t` with values IDLE, RUN, DONE, 2-bit encoding;
  - default constants `N_REQ_DEF = 4` and `CNT_W_DEF = 8`.
- Sub-module `rr_arbiter`:
  - pure combinational;
  - inputs: `req[N_REQ]` and `ptr`;
  - outputs: one-hot `gnt[N_REQ]`, `gnt_idx`, `any`.
- Top level holds the FSM, `len_q`, the counter and `ptr`. The counter is inline and clears and increments under FSM control only.

## Test plan
- **Single request:** reset for 2 cycles, then `req_valid[1] = 1`, `req_len[1] = 5`.
  - `req_ready[1]` is high one cycle.
  - `count` reads 0, 1, 2, 3, 4 over the next 5 cycles.
  - `done[1]` is high on the cycle after that, with `busy = 1` throughout.
- **Zero length:** `req_len[2] = 0`.
  - `req_ready[2]` high, then `done[2]` on the very next cycle.
  - `count` stays 0.
- **Round-robin fairness:** all four requesters hold `req_valid` with `req_len = 3`.
  - Grant order is 0, 1, 2, 3, 0, 1, …
  - `done` arrives every 5 cycles.
  - No requester is granted twice before the other three are each granted once.
- **Pointer resume:** after requester 2 completes, assert only `req_valid[0]` and `req_valid[3]` together.
  - Requester 3 is granted first, then 0.
- **Maximum length:** `req_len[0] = 255`.
  - `count` reaches 254 with no wrap.
  - `done[0]` arrives at accept+256.
- **Reset mid-run:** assert `reset` for one cycle when `count == 2` of a length-10 job.
  - No `done` is pulsed.
  - `count = 0`, `busy = 0`, `ptr = 0` the cycle after.
  - With `req_valid[3]` held, requester 3 is then re-granted.
